// File: rtl/request_sequencer.sv
// ----------------------------------------------------------------------------
// request_sequencer
//
// Initiator side of the LED-walker request/busy handshake. Single-cycle
// upstream events are collected in a saturating pending counter. One request
// at a time is offered to the walker, and only while it reports idle. Each
// request is tracked through acceptance (busy rises) and completion (busy
// falls). A request that is never accepted is abandoned after TIMEOUT_CYCLES.
//
// Parameters:
//   PW             - pending-counter width; up to 2^PW-1 queued requests
//   TIMEOUT_CYCLES - cycles o_request may wait for i_busy before abandoning
//
// Ports:
//   i_clk      - system clock
//   i_reset    - synchronous, active-high reset
//   i_event    - single-cycle request pulse from the upstream source
//   i_clear    - single-cycle pulse clearing o_overflow and o_timeout
//   i_busy     - walker busy
//   o_request  - request to the walker (registered)
//   o_pending  - queued requests, including the one in flight
//   o_done     - one-cycle pulse when a walk completes
//   o_overflow - sticky: an event was dropped because the counter was full
//   o_timeout  - sticky: a request was abandoned after TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module request_sequencer #(
    parameter int PW             = 3,
    parameter int TIMEOUT_CYCLES = 24_000_000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_event,
    input  logic          i_clear,
    input  logic          i_busy,
    output logic          o_request,
    output logic [PW-1:0] o_pending,
    output logic          o_done,
    output logic          o_overflow,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PENDING_MAX  = '1;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic          request_q, request_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;

    // One queued request leaves the counter (completion or abandonment).
    logic dec;
    logic timeout_set;
    logic overflow_set;

    // Handshake state machine.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        request_d   = request_q;
        done_d      = 1'b0;
        dec         = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                request_d = 1'b0;
                timer_d   = '0;
                if ((pending_q != '0) && !i_busy) begin
                    state_d   = S_REQ;
                    request_d = 1'b1;
                end
            end
            S_REQ: begin
                request_d = 1'b1;
                // Acceptance takes priority over an expiring timer.
                if (i_busy) begin
                    state_d   = S_BUSY;
                    request_d = 1'b0;
                    timer_d   = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = S_IDLE;
                    request_d   = 1'b0;
                    timer_d     = '0;
                    timeout_set = 1'b1;
                    dec         = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_BUSY: begin
                request_d = 1'b0;
                // A glitch that already fell is completed on the first
                // low cycle seen here.
                if (!i_busy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    dec     = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                request_d = 1'b0;
                timer_d   = '0;
            end
        endcase
    end

    // Pending counter: an event landing on a decrement cancels it out, so a
    // full counter does not report overflow in that cycle. Decrements only
    // happen from REQ/BUSY where the count is at least one.
    always_comb begin
        pending_d    = pending_q;
        overflow_set = 1'b0;
        if (i_event && !dec) begin
            if (pending_q != PENDING_MAX) begin
                pending_d = pending_q + 1'b1;
            end else begin
                overflow_set = 1'b1;
            end
        end else if (!i_event && dec) begin
            pending_d = pending_q - 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as i_clear leaves the flag set.
    always_comb begin
        overflow_d = (overflow_q & ~i_clear) | overflow_set;
        timeout_d  = (timeout_q & ~i_clear) | timeout_set;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            request_q  <= 1'b0;
            pending_q  <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            request_q  <= request_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_request  = request_q;
    assign o_pending  = pending_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_request_sequencer.sv
// ----------------------------------------------------------------------------
// tb_request_sequencer
//
// Drives request_sequencer (PW=3, TIMEOUT_CYCLES=20) against a behavioural
// walker with a 4-cycle strobe and an 11-step walk. Expected o_pending values
// after each completion are queued when events are driven and popped when
// o_done pulses. One task per scenario, run in sequence.
// ----------------------------------------------------------------------------
module tb_request_sequencer;

    localparam int PW      = 3;
    localparam int TIMEOUT = 20;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_event = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_busy;
    logic          o_request;
    logic [PW-1:0] o_pending;
    logic          o_done;
    logic          o_overflow;
    logic          o_timeout;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_count   = 0;
    int exp_q[$];

    // Walker model and busy override.
    logic       walker_en   = 1'b1;
    logic       walker_busy = 1'b0;
    logic       busy_force  = 1'b0;
    logic [1:0] strobe_cnt  = 2'd0;
    logic [3:0] step        = 4'd0;
    logic       strobe;

    assign strobe = (strobe_cnt == 2'd3);
    assign i_busy = walker_busy | busy_force;

    always #5 clk = ~clk;

    request_sequencer #(
        .PW             (PW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_event    (i_event),
        .i_clear    (i_clear),
        .i_busy     (i_busy),
        .o_request  (o_request),
        .o_pending  (o_pending),
        .o_done     (o_done),
        .o_overflow (o_overflow),
        .o_timeout  (o_timeout)
    );

    // The walker latches a request on a strobe, then takes 11 strobes to walk.
    always @(posedge clk) begin
        strobe_cnt <= strobe_cnt + 2'd1;
        if (!walker_en) begin
            walker_busy <= 1'b0;
            step        <= 4'd0;
        end else if (!walker_busy) begin
            if (o_request && strobe) begin
                walker_busy <= 1'b1;
                step        <= 4'd10;
            end
        end else if (strobe) begin
            if (step == 4'd0) walker_busy <= 1'b0;
            else              step <= step - 4'd1;
        end
    end

    always @(posedge clk) begin
        if (o_done === 1'b1) begin
            done_count <= done_count + 1;
            $display("[TB] t=%0t walk done, pending=%0d", $time, o_pending);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (o_done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_busy(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i_busy === level) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) tick();
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL reset_request: got %b expected 0", o_request); end
        tests_run++; if (o_pending !== 3'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d expected 0", o_pending); end
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", o_done); end
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b expected 0", o_timeout); end
        i_reset = 1'b0;
        repeat (2) tick();
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL idle_no_request: got %b expected 0", o_request); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        bit ok;
        int exp;
        repeat (4) tick();
        i_event = 1'b1;
        exp_q.push_back(0);
        tick();
        i_event = 1'b0;
        tests_run++; if (o_pending !== 3'd1) begin tests_failed++; $display("FAIL single_pending: got %0d expected 1", o_pending); end
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL single_req_early: got %b expected 0", o_request); end
        tick();
        tests_run++; if (o_request !== 1'b1) begin tests_failed++; $display("FAIL single_req_rise: got %b expected 1", o_request); end
        wait_busy(1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_accept: got no busy expected busy within 100 cycles"); end
        tests_run++; if (o_request !== 1'b1) begin tests_failed++; $display("FAIL single_req_held: got %b expected 1", o_request); end
        tick();
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL single_req_drop: got %b expected 0", o_request); end
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_done: got no o_done expected pulse within 200 cycles"); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        tests_run++; if (o_pending !== 3'(exp)) begin tests_failed++; $display("FAIL single_pending_after: got %0d expected %0d", o_pending, exp); end
        tick();
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL single_done_width: got %b expected 0", o_done); end
        $display("[TB] single request checked");
    endtask

    task automatic test_back_to_back();
        bit ok;
        int exp;
        i_event = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(2 - k);
            tick();
        end
        i_event = 1'b0;
        tests_run++; if (o_pending !== 3'd3) begin tests_failed++; $display("FAIL b2b_pending3: got %0d expected 3", o_pending); end
        for (int k = 0; k < 3; k++) begin
            wait_done(ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_done%0d: got no o_done expected pulse", k); end
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            tests_run++; if (o_pending !== 3'(exp)) begin tests_failed++; $display("FAIL b2b_pending_step%0d: got %0d expected %0d", k, o_pending, exp); end
            tick();
            tests_run++; if (o_request !== ((k < 2) ? 1'b1 : 1'b0)) begin tests_failed++; $display("FAIL b2b_next_req%0d: got %b expected %b", k, o_request, (k < 2)); end
        end
        $display("[TB] back-to-back checked");
    endtask

    task automatic test_overflow();
        bit ok;
        int exp;
        busy_force = 1'b1;
        tick();
        i_event = 1'b1;
        repeat (9) tick();
        i_event = 1'b0;
        tests_run++; if (o_pending !== 3'd7) begin tests_failed++; $display("FAIL ovf_saturate: got %0d expected 7", o_pending); end
        tests_run++; if (o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", o_overflow); end
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL ovf_no_req_busy: got %b expected 0", o_request); end
        // Set and clear in the same cycle: set wins.
        i_event = 1'b1;
        i_clear = 1'b1;
        tick();
        i_event = 1'b0;
        i_clear = 1'b0;
        tests_run++; if (o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_wins: got %b expected 1", o_overflow); end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b expected 0", o_overflow); end
        for (int k = 7; k >= 0; k--) exp_q.push_back(k);
        busy_force = 1'b0;
        wait_busy(1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_accept: got no busy expected busy"); end
        wait_busy(1'b0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_walk_end: got busy expected idle"); end
        // Busy just fell; the sequencer completes on the next edge, together
        // with this event.
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        tests_run++; if (o_done !== 1'b1) begin tests_failed++; $display("FAIL ovf_coincide_done: got %b expected 1", o_done); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        tests_run++; if (o_pending !== 3'(exp)) begin tests_failed++; $display("FAIL ovf_coincide_pending: got %0d expected %0d", o_pending, exp); end
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_coincide_flag: got %b expected 0", o_overflow); end
        for (int k = 0; k < 7; k++) begin
            wait_done(ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_drain%0d: got no o_done expected pulse", k); end
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            tests_run++; if (o_pending !== 3'(exp)) begin tests_failed++; $display("FAIL ovf_drain_pending%0d: got %0d expected %0d", k, o_pending, exp); end
        end
        $display("[TB] overflow checked");
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        int dones_before;
        walker_en = 1'b0;
        repeat (2) tick();
        dones_before = done_count;
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o_request === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL to_req_rise: got no request expected request"); end
        hi = 0;
        while (o_request === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        tests_run++; if (hi != TIMEOUT) begin tests_failed++; $display("FAIL to_req_width: got %0d expected %0d", hi, TIMEOUT); end
        tests_run++; if (o_timeout !== 1'b1) begin tests_failed++; $display("FAIL to_flag: got %b expected 1", o_timeout); end
        tests_run++; if (o_pending !== 3'd0) begin tests_failed++; $display("FAIL to_pending: got %0d expected 0", o_pending); end
        tick();
        tests_run++; if (done_count != dones_before) begin tests_failed++; $display("FAIL to_no_done: got %0d expected %0d", done_count, dones_before); end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("FAIL to_clear: got %b expected 0", o_timeout); end
        walker_en = 1'b1;
        $display("[TB] timeout checked");
    endtask

    task automatic test_busy_at_start();
        bit ok;
        bit bad;
        int exp;
        busy_force = 1'b1;
        tick();
        i_event = 1'b1;
        exp_q.push_back(0);
        tick();
        i_event = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            if (o_request !== 1'b0) bad = 1'b1;
            tick();
        end
        tests_run++; if (bad) begin tests_failed++; $display("FAIL bas_held_off: got request expected none while busy"); end
        tests_run++; if (o_pending !== 3'd1) begin tests_failed++; $display("FAIL bas_pending: got %0d expected 1", o_pending); end
        busy_force = 1'b0;
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL bas_req_before: got %b expected 0", o_request); end
        tick();
        tests_run++; if (o_request !== 1'b1) begin tests_failed++; $display("FAIL bas_req_after: got %b expected 1", o_request); end
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bas_done: got no o_done expected pulse"); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        tests_run++; if (o_pending !== 3'(exp)) begin tests_failed++; $display("FAIL bas_pending_after: got %0d expected %0d", o_pending, exp); end
        $display("[TB] busy-at-start checked");
    endtask

    task automatic test_reset_mid_walk();
        bit ok;
        bit bad;
        int exp;
        i_event = 1'b1;
        repeat (2) tick();
        i_event = 1'b0;
        wait_busy(1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmw_accept: got no busy expected busy"); end
        tick();
        tests_run++; if (o_pending !== 3'd2) begin tests_failed++; $display("FAIL rmw_pending2: got %0d expected 2", o_pending); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_q.delete();
        tests_run++; if (o_request !== 1'b0) begin tests_failed++; $display("FAIL rmw_request: got %b expected 0", o_request); end
        tests_run++; if (o_pending !== 3'd0) begin tests_failed++; $display("FAIL rmw_pending: got %0d expected 0", o_pending); end
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL rmw_done: got %b expected 0", o_done); end
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL rmw_overflow: got %b expected 0", o_overflow); end
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("FAIL rmw_timeout: got %b expected 0", o_timeout); end
        bad = 1'b0;
        repeat (80) begin
            tick();
            if (o_request !== 1'b0 || o_done !== 1'b0) bad = 1'b1;
        end
        tests_run++; if (bad) begin tests_failed++; $display("FAIL rmw_quiet: got request/done expected none after reset"); end
        i_event = 1'b1;
        exp_q.push_back(0);
        tick();
        i_event = 1'b0;
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmw_new_done: got no o_done expected pulse"); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        tests_run++; if (o_pending !== 3'(exp)) begin tests_failed++; $display("FAIL rmw_new_pending: got %0d expected %0d", o_pending, exp); end
        $display("[TB] reset mid-walk checked");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_busy_at_start();
        test_reset_mid_walk();
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/request_sequencer.md
Name: request_sequencer

Overview:
- Initiator side of the LED-walker request/busy handshake.
- Collects 1-cycle event pulses from an upstream source, e.g. a debounced button or a UART byte strobe, into a saturating pending counter.
- Issues requests to the walker one at a time, each only when the walker reports idle.
- Tracks each request through acceptance (busy rises) and completion (busy falls); reports completion, overflow and acceptance-timeout status.

Parameters:
- PW, 3: pending-counter width. Maximum queued requests = 2^PW-1.
- TIMEOUT_CYCLES, 24_000_000: cycles o_request may stay high without i_busy rising before the request is abandoned. Default is two walker strobe periods at 12 MHz.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_event  input  1  single-cycle request pulse from the upstream source
- i_clear  input  1  single-cycle pulse; clears o_overflow and o_timeout
- i_busy  input  1  walker busy, driven by the walker's o_busy
- o_request  output  1  request to the walker, driving its i_request; registered
- o_pending  output  PW  requests queued, including the one in flight
- o_done  output  1  one-cycle pulse when a walk completes
- o_overflow  output  1  sticky; an event was dropped because the counter was full
- o_timeout  output  1  sticky; a request was abandoned after TIMEOUT_CYCLES

Behaviour:
- Reset values: o_request=0, o_pending=0, o_done=0, o_overflow=0, o_timeout=0, state=IDLE, timeout counter=0. All outputs are registered.
- State IDLE:
  - If o_pending!=0 and i_busy==0, go to REQ; o_request=1 from the next cycle.
  - If i_busy==1 (walker still finishing, or driven by another initiator), stay in IDLE.
- State REQ:
  - Hold o_request=1 and increment the 32-bit timeout counter each cycle.
  - If i_busy==1, go to BUSY, drop o_request next cycle, clear the timeout counter.
  - Else, if the counter reaches TIMEOUT_CYCLES-1, then on the next edge: drop o_request, set o_timeout, decrement o_pending, clear the counter, go to IDLE.
  - If both conditions hold in the same cycle, i_busy wins: no timeout.
- State BUSY:
  - Wait for i_busy==0.
  - On that cycle: o_done=1 for exactly one cycle, decrement o_pending, go to IDLE.
  - No minimum gap is enforced; a new request can rise 1 cycle after o_done.
- Request latency: o_request rises exactly 1 cycle after the IDLE entry condition holds. It is never asserted while i_busy was high in the previous cycle, except for the single cycle after acceptance.
- Pending counter (events are never double-counted):
  - i_event with no decrement: increment if o_pending<2^PW-1. Otherwise drop the event and set o_overflow.
  - i_event with a decrement in the same cycle: count unchanged, no overflow, even when full.
  - Decrement alone: count-1. Decrement only occurs from REQ/BUSY, so count is ≥1 and cannot underflow.
- Sticky flags:
  - o_overflow and o_timeout are cleared by i_reset or i_clear.
  - If a set condition and i_clear coincide, the flag ends set (set wins).
- Reset mid-operation:
  - Everything returns to reset values on the next edge and queued events are discarded.
  - The walker finishes its current walk independently.
  - After reset, the sequencer waits in IDLE for both a new event and i_busy==0.
- i_busy glitch in REQ (rises then falls before BUSY is registered): BUSY is entered on the rise, and completion is taken on the first cycle i_busy==0 in BUSY.

Test Plan:
- Bench setup: PW=3, TIMEOUT_CYCLES=20; walker model with 4-cycle strobe and 11-step walk.
- Single request: one i_event pulse at cycle 10.
  - o_pending=1 at cycle 11, o_request=1 at cycle 12, held until the cycle after i_busy rises.
  - o_done pulses once when i_busy falls; o_pending returns to 0.
- Back-to-back queue: 3 i_event pulses in consecutive cycles.
  - o_pending=3, then exactly 3 walks, each o_request rising 1 cycle after the prior o_done.
  - o_pending steps 3→2→1→0 on each o_done.
- Overflow: 9 i_event pulses while the walker is held busy.
  - o_pending saturates at 7 and o_overflow=1.
  - An event coincident with a completion decrement leaves o_pending=7 with no new overflow.
  - i_clear pulse → o_overflow=0.
- Timeout: i_busy tied 0, one i_event.
  - o_request high for 20 cycles, then drops; o_timeout=1, o_pending=0, o_done never pulses.
- Busy-at-start: i_busy=1 when i_event arrives.
  - o_request stays 0 until 1 cycle after i_busy falls, then the request proceeds normally.
- Reset mid-walk: assert i_reset while in BUSY with o_pending=2.
  - Next cycle: all outputs 0.
  - No request issued after the walker finishes, until a new i_event arrives.
